parity_engine: RTL and testbench
================================

Name: parity_engine

Overview:
- Serial, frame-aware parity engine for the UART TX and RX paths. It is the parametrised successor to the combinational parity generator.
- It accumulates parity one bit at a time as data bits are shifted.
- Supports none/even/odd/mark/space modes.
- Generate mode: emits the frame parity bit. Check mode: compares the received parity bit and flags an error.

Parameters:
- WIDTH, 8, data bits per frame; legal range 5..9.
- CNT_W, $clog2(WIDTH+1), width of bit_cnt; derived, do not override.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin new frame; latches par_mode and chk_en, clears accumulator.
- par_mode  input  3  0=none, 1=even, 2=odd, 3=mark, 4=space; 5..7 treated as none.
- chk_en  input  1  1=check mode (RX), 0=generate mode (TX).
- bit_valid  input  1  qualifies bit_in for one cycle.
- bit_in  input  1  serial data bit (LSB first), or the received parity bit in the PAR state.
- busy  output  1  high in DATA or PAR.
- bit_cnt  output  CNT_W  data bits accepted in current frame.
- p_out  output  1  expected parity bit; valid while p_valid.
- p_valid  output  1  one-cycle pulse when all WIDTH data bits accepted.
- chk_done  output  1  one-cycle pulse after parity bit checked.
- par_err  output  1  sticky mismatch flag; cleared by start or rst.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; busy, bit_cnt, p_out, p_valid, chk_done, par_err, accumulator all 0; latched mode=none.
  - Reset mid-frame aborts the frame; no pulses are produced.
- States: IDLE, DATA, PAR.
- IDLE:
  - bit_valid ignored.
  - On start -> DATA; acc=0, bit_cnt=0, par_err=0; mode latched.
- DATA:
  - Each bit_valid: acc ^= bit_in, bit_cnt++.
  - Gaps of any length between bit_valid pulses are legal.
  - On the cycle the WIDTH-th bit is accepted, the next cycle shows p_valid=1 and p_out set from the final acc:
    - even: p_out = acc
    - odd: p_out = ~acc
    - mark: p_out = 1
    - space: p_out = 0
    - none: p_out = 0
  - bit_cnt holds WIDTH until next start.
  - Transition on that same edge: -> PAR if chk_en latched=1 and mode!=none, else -> IDLE.
- PAR:
  - The next bit_valid samples bit_in as the received parity.
  - The following cycle shows chk_done=1 and par_err = (bit_in != p_out); state -> IDLE.
  - p_out holds its value through PAR.
- Generate mode and mode none never assert chk_done or par_err.
- Latency:
  - p_valid: 1 cycle after the last data bit.
  - chk_done: 1 cycle after the parity bit.
- start while busy: abort the current frame and restart (same as from IDLE).
  - No p_valid or chk_done for the aborted frame.
  - par_err cleared.
- start and bit_valid in the same cycle: start wins; the bit is discarded (bit_cnt=0 next cycle).
- start on the same cycle a pulse would fire: the pulse for the finished frame still appears (it is registered from the prior edge). The new frame begins.
- rst has priority over start.
- p_valid and chk_done are never high simultaneously.
- par_mode and chk_en changes mid-frame have no effect (latched at start).

Test Plan:
- Even generate, WIDTH=8:
  - start, par_mode=1, chk_en=0; send 0xA5 LSB-first with bit_valid every cycle.
  - -> p_valid single pulse 1 cycle after 8th bit, p_out=0, bit_cnt=8, busy drops, chk_done never high.
  - Repeat with par_mode=2 -> p_out=1.
- Odd check, correct and corrupted parity:
  - start, par_mode=2, chk_en=1; send 0x01, then parity bit 0 -> chk_done pulse, par_err=0.
  - Rerun with parity bit 1 -> par_err=1, held until next start, then cleared.
- Mark/space/none check:
  - mark with parity bit 0 -> par_err=1.
  - space with parity bit 0 -> par_err=0.
  - par_mode=0 or 6 with chk_en=1 -> p_out=0, no PAR state, no chk_done.
- Gapped bits and abort:
  - send 0x0F with 0–3 idle cycles between bit_valid -> even p_out=0.
  - Separate run: start after 4 bits, with bit_valid high the same cycle -> bit discarded, bit_cnt=0, no p_valid for the aborted frame.
  - Subsequent full frame computes correctly.
- Reset mid-frame:
  - assert rst after 5 bits, and separately during PAR -> next cycle all outputs 0, state IDLE.
  - Following bit_valid without start ignored (bit_cnt stays 0).

Source files
------------

// File: rtl/parity_engine_if.sv
// Handshake bundle between a UART shifter and the parity engine.
// The shifter (master) drives frame control and serial bits; the engine (slave) reports parity status.
interface parity_engine_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic [2:0]       par_mode;
  logic             chk_en;
  logic             bit_valid;
  logic             bit_in;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             p_out;
  logic             p_valid;
  logic             chk_done;
  logic             par_err;

  modport master (
    output start, par_mode, chk_en, bit_valid, bit_in,
    input  busy, bit_cnt, p_out, p_valid, chk_done, par_err
  );

  modport slave (
    input  start, par_mode, chk_en, bit_valid, bit_in,
    output busy, bit_cnt, p_out, p_valid, chk_done, par_err
  );
endinterface

// File: rtl/parity_engine.sv
// Serial, frame-aware parity engine for UART TX (generate) and RX (check) paths.
// Accumulates parity LSB-first over WIDTH data bits, then emits or checks the parity bit.
module parity_engine #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  parity_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR
  } state_t;

  typedef enum logic [2:0] {
    M_NONE  = 3'd0,
    M_EVEN  = 3'd1,
    M_ODD   = 3'd2,
    M_MARK  = 3'd3,
    M_SPACE = 3'd4
  } mode_t;

  function automatic mode_t decode_mode(logic [2:0] m);
    return (m <= 3'd4) ? mode_t'(m) : M_NONE;
  endfunction

  function automatic logic parity_bit(mode_t m, logic acc);
    case (m)
      M_EVEN:  return acc;
      M_ODD:   return ~acc;
      M_MARK:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic             chk_q, chk_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             p_out_q, p_out_d;
  logic             p_valid_q, p_valid_d;
  logic             chk_done_q, chk_done_d;
  logic             par_err_q, par_err_d;
  logic             acc_next;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    chk_d      = chk_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    p_out_d    = p_out_q;
    p_valid_d  = 1'b0;
    chk_done_d = 1'b0;
    par_err_d  = par_err_q;
    acc_next   = acc_q ^ bus.bit_in;

    // start aborts anything in flight and wins over a coincident bit_valid
    if (bus.start) begin
      state_d   = S_DATA;
      mode_d    = decode_mode(bus.par_mode);
      chk_d     = bus.chk_en;
      acc_d     = 1'b0;
      cnt_d     = '0;
      p_out_d   = 1'b0;
      par_err_d = 1'b0;
    end else begin
      case (state_q)
        S_DATA: begin
          if (bus.bit_valid) begin
            acc_d = acc_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              p_valid_d = 1'b1;
              p_out_d   = parity_bit(mode_q, acc_next);
              state_d   = (chk_q && mode_q != M_NONE) ? S_PAR : S_IDLE;
            end
          end
        end
        S_PAR: begin
          if (bus.bit_valid) begin
            chk_done_d = 1'b1;
            par_err_d  = (bus.bit_in != p_out_q);
            state_d    = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= M_NONE;
      chk_q      <= 1'b0;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      p_out_q    <= 1'b0;
      p_valid_q  <= 1'b0;
      chk_done_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      chk_q      <= chk_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      p_out_q    <= p_out_d;
      p_valid_q  <= p_valid_d;
      chk_done_q <= chk_done_d;
      par_err_q  <= par_err_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.bit_cnt  = cnt_q;
  assign bus.p_out    = p_out_q;
  assign bus.p_valid  = p_valid_q;
  assign bus.chk_done = chk_done_q;
  assign bus.par_err  = par_err_q;

endmodule

// File: tb/tb_parity_engine.sv
// Directed bench for parity_engine: stimulus pushes expected pulses into a scoreboard,
// an independent monitor pops and compares them whenever p_valid or chk_done fires.
module tb_parity_engine;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef struct {
    bit is_chk;
    bit val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  parity_engine_if #(.WIDTH(WIDTH)) bus ();

  parity_engine #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(logic [2:0] mode, logic chk);
    bus.start    = 1'b1;
    bus.par_mode = mode;
    bus.chk_en   = chk;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bit(logic b);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    tick();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  // gapped=1 inserts 0..3 idle cycles before each bit
  task automatic send_byte(logic [WIDTH-1:0] data, bit gapped, bit exp_p);
    sb.push_back('{is_chk: 1'b0, val: exp_p});
    for (int i = 0; i < WIDTH; i++) begin
      if (gapped) repeat (i % 4) tick();
      send_bit(data[i]);
    end
  endtask

  task automatic send_parity(logic b, bit exp_err);
    sb.push_back('{is_chk: 1'b1, val: exp_err});
    send_bit(b);
  endtask

  task automatic check_idle(string name);
    check({name, ".busy"},     32'(bus.busy),     0);
    check({name, ".bit_cnt"},  32'(bus.bit_cnt),  0);
    check({name, ".p_out"},    32'(bus.p_out),    0);
    check({name, ".p_valid"},  32'(bus.p_valid),  0);
    check({name, ".chk_done"}, 32'(bus.chk_done), 0);
    check({name, ".par_err"},  32'(bus.par_err),  0);
  endtask

  // Monitor: every output pulse must match the oldest scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.p_valid && bus.chk_done) check("pulse_exclusive", 1, 0);
      if (bus.p_valid) begin
        if (sb.size() == 0) check("unexpected_p_valid", 1, 0);
        else begin
          e = sb.pop_front();
          check("pulse_kind_pv", 32'(e.is_chk), 0);
          check("p_out", 32'(bus.p_out), 32'(e.val));
        end
      end
      if (bus.chk_done) begin
        if (sb.size() == 0) check("unexpected_chk_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("pulse_kind_cd", 32'(e.is_chk), 1);
          check("par_err", 32'(bus.par_err), 32'(e.val));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.par_mode = 3'd0; bus.chk_en = 1'b0;
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    tick(); tick();
    check_idle("reset");
    rst = 1'b0;
    send_bit(1'b1);
    check("idle_ignores_bit", 32'(bus.bit_cnt), 0);

    // Even generate 0xA5 (4 ones) -> 0; odd -> 1; second start lands on the pulse cycle
    start_frame(3'd1, 1'b0);
    check("busy_after_start", 32'(bus.busy), 1);
    send_byte(8'hA5, 1'b0, 1'b0);
    check("gen_bit_cnt", 32'(bus.bit_cnt), WIDTH);
    check("gen_busy_drop", 32'(bus.busy), 0);
    start_frame(3'd2, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b1);
    repeat (3) tick();
    check("gen_no_chk_err", 32'(bus.par_err), 0);

    // Odd check 0x01: p_out=0; mid-frame mode/chk_en changes must be ignored
    start_frame(3'd2, 1'b1);
    bus.par_mode = 3'd3; bus.chk_en = 1'b0;
    send_byte(8'h01, 1'b0, 1'b0);
    check("chk_busy_in_par", 32'(bus.busy), 1);
    send_parity(1'b0, 1'b0);
    check("chk_busy_after", 32'(bus.busy), 0);

    start_frame(3'd2, 1'b1);
    send_byte(8'h01, 1'b0, 1'b0);
    send_parity(1'b1, 1'b1);
    repeat (4) tick();
    check("par_err_sticky", 32'(bus.par_err), 1);
    start_frame(3'd1, 1'b0);
    check("par_err_cleared", 32'(bus.par_err), 0);
    send_byte(8'h00, 1'b0, 1'b0);

    // Mark/space check
    start_frame(3'd3, 1'b1);
    send_byte(8'h01, 1'b0, 1'b1);
    send_parity(1'b0, 1'b1);
    start_frame(3'd4, 1'b1);
    send_byte(8'h01, 1'b0, 1'b0);
    send_parity(1'b0, 1'b0);

    // None / reserved modes with chk_en: no PAR state, no chk_done
    start_frame(3'd0, 1'b1);
    send_byte(8'hFF, 1'b0, 1'b0);
    check("none_no_par", 32'(bus.busy), 0);
    start_frame(3'd6, 1'b1);
    send_byte(8'h01, 1'b0, 1'b0);
    check("mode6_no_par", 32'(bus.busy), 0);
    send_bit(1'b1);

    // Gapped 0x0F even -> 0
    start_frame(3'd1, 1'b0);
    send_byte(8'h0F, 1'b1, 1'b0);

    // Abort after 4 bits with bit_valid on the restart cycle
    start_frame(3'd1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("abort_cnt4", 32'(bus.bit_cnt), 4);
    bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    start_frame(3'd1, 1'b0);
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    check("abort_bit_discarded", 32'(bus.bit_cnt), 0);
    check("abort_busy", 32'(bus.busy), 1);
    send_byte(8'h07, 1'b0, 1'b1);

    // Reset mid-DATA after 5 bits
    start_frame(3'd2, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst = 1'b1;
    tick();
    check_idle("rst_data");
    rst = 1'b0;
    send_bit(1'b1);
    check("rst_data_ignore", 32'(bus.bit_cnt), 0);

    // Reset while in PAR
    start_frame(3'd2, 1'b1);
    send_byte(8'h03, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    check_idle("rst_par");
    rst = 1'b0;
    send_bit(1'b1);
    check("rst_par_ignore", 32'(bus.bit_cnt), 0);
    repeat (3) tick();

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
